// File: rtl/dp_ram_burst_reader.sv
// rtl/dp_ram_burst_reader.sv - burst read controller for a pipelined dual-port RAM read port
// Issues credit-limited reads, captures returning words into a small FIFO, streams them out.
module dp_ram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int STAGES = RD_LATENCY + 1;
  localparam int SUM_W  = $clog2(FIFO_DEPTH + STAGES + 2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   remaining;
  logic [STAGES-1:0]       pipe_vld;
  logic [STAGES-1:0]       pipe_last;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [SUM_W-1:0]        inflight_count;
  logic                    accept;
  logic                    issue;
  logic                    issue_last;
  logic                    push;
  logic                    pop;
  logic                    credit_ok;
  logic                    drained;

  // Stage 0 of the flag pipeline lines up with addrb; the last stage lines up with dob.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight_count = inflight_count + SUM_W'(pipe_vld[i]);
    end
    pop        = (fifo_count != '0) && m_tready;
    push       = pipe_vld[STAGES-1];
    // A beat leaving the FIFO this cycle frees its slot for the read issued now.
    credit_ok  = (SUM_W'(fifo_count) + inflight_count) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));
    accept     = (state == IDLE) && cmd_valid;
    issue      = accept || ((state == READ) && credit_ok);
    issue_last = accept ? (cmd_len == '0) : (remaining == ADDR_WIDTH'(1));
    drained    = (inflight_count == '0) &&
                 ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= dob;
      fifo_last[wr_ptr] <= pipe_last[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state      <= IDLE;
      addrb      <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pipe_vld   <= {pipe_vld[STAGES-2:0], issue};
      pipe_last  <= {pipe_last[STAGES-2:0], issue && issue_last};
      if (issue) begin
        addrb <= accept ? cmd_addr : cur_addr;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

      // The accept cycle issues the first word, so remaining counts words still to issue.
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr + ADDR_WIDTH'(1);
            remaining <= cmd_len;
            state     <= (cmd_len == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (credit_ok) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - ADDR_WIDTH'(1);
            if (remaining == ADDR_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_tvalid  = (fifo_count != '0);
  assign m_tdata   = fifo_data[rd_ptr];
  assign m_tlast   = m_tvalid && fifo_last[rd_ptr];
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dp_ram_burst_reader.sv
// tb/tb_dp_ram_burst_reader.sv - self-checking bench for dp_ram_burst_reader
// RAM holds ram[i] = i + 0x100 behind a 3-cycle read pipeline.
module tb_dp_ram_burst_reader;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  addrb;
  logic [31:0] dob;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic [31:0] d1, d2;
  logic [31:0] ram [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dp_ram_burst_reader dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .addrb      (addrb),
    .dob        (dob),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .busy       (busy)
  );

  always @(posedge clk) begin
    d1  <= ram[addrb];
    d2  <= d1;
    dob <= d2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4) == 0;
      2:       return 1'($urandom_range(0, 1));
      3:       return k >= 12;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: cmd_ready=%b required 1 within 400 cycles", cmd_ready);
    end
  endtask

  // Runs one burst and checks every beat against data = 0x100 + ((a+i) mod 256).
  task automatic run_burst(input int a, input int len, input int mode, input bit chk_hold,
                           output int first_k);
    int          n = len + 1;
    int          got = 0;
    int          k;
    int          budget = n * 8 + 60;
    bit          prev_stall = 1'b0;
    bit          rdy;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic [31:0] exp_d;
    logic        exp_l;
    first_k = -1;
    wait_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 8'(a);
    cmd_len   = 8'(len);
    m_tready  = 1'b0;
    tick();
    cmd_valid = 1'b0;
    k = 1;
    checks++;
    if (addrb !== 8'(a)) begin
      errors++;
      $display("FAIL addrb_first: got %h required %h", addrb, 8'(a));
    end
    while (got < n && k < budget) begin
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_burst: k=%0d busy=%b cmd_ready=%b required 1/0", k, busy, cmd_ready);
      end
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
          errors++;
          $display("FAIL stall_hold: k=%0d valid=%b data=%h last=%b required 1 %h %b",
                   k, m_tvalid, m_tdata, m_tlast, pd, pl);
        end
      end
      if (chk_hold && k >= 5 && k < 12) begin
        checks++;
        if (addrb !== 8'(a + 3)) begin
          errors++;
          $display("FAIL credit_hold: k=%0d addrb=%h required %h", k, addrb, 8'(a + 3));
        end
      end
      if (mode == 1) begin
        checks++;
        if (dut.fifo_count > 3'd4) begin
          errors++;
          $display("FAIL fifo_bound: k=%0d fifo_count=%0d required <=4", k, dut.fifo_count);
        end
      end
      rdy = pick_ready(mode, k);
      m_tready = rdy;
      if (m_tvalid === 1'b1 && rdy) begin
        exp_d = 32'h100 + 32'((a + got) % 256);
        exp_l = (got == n - 1);
        checks++;
        if (m_tdata !== exp_d || m_tlast !== exp_l) begin
          errors++;
          $display("FAIL beat: idx=%0d data=%h last=%b required %h %b", got, m_tdata, m_tlast, exp_d, exp_l);
        end
        if (got == 0) first_k = k;
        got++;
      end
      prev_stall = (m_tvalid === 1'b1) && !rdy;
      pd = m_tdata;
      pl = m_tlast;
      tick();
      k++;
    end
    m_tready = 1'b0;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL burst_timeout: beats=%0d required %0d", got, n);
    end else if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_last: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    cmd_valid  = 1'b1;
    cmd_addr   = 8'h55;
    cmd_len    = 8'h00;
    m_tready   = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || addrb !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b last=%b addrb=%h required 1 0 0 0 00",
               cmd_ready, busy, m_tvalid, m_tlast, addrb);
    end
    sync_reset = 1'b0;
    cmd_valid  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single();
    int fk;
    run_burst(8'h10, 0, 0, 1'b0, fk);
    checks++;
    if (fk != 5) begin
      errors++;
      $display("FAIL single_latency: first beat at %0d required 5", fk);
    end
  endtask

  task automatic test_full_wrap();
    int fk;
    run_burst(8'hF0, 8'hFF, 0, 1'b0, fk);
  endtask

  task automatic test_backpressure();
    int fk;
    run_burst(0, 15, 1, 1'b0, fk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [$];
    bit          exp_l [$];
    int          got = 0;
    int          k = 0;
    bit          b_acc = 1'b0;
    for (int i = 0; i < 4; i++) begin exp_d.push_back(32'h120 + 32'(i)); exp_l.push_back(i == 3); end
    for (int i = 0; i < 2; i++) begin exp_d.push_back(32'h140 + 32'(i)); exp_l.push_back(i == 1); end
    wait_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 8'h20;
    cmd_len   = 8'd3;
    m_tready  = 1'b1;
    tick();
    cmd_addr = 8'h40;
    cmd_len  = 8'd1;
    while (got < 6 && k < 200) begin
      if (cmd_valid && cmd_ready === 1'b1) begin
        checks++;
        if (got != 4) begin
          errors++;
          $display("FAIL b_accept: accepted after %0d beats required 4", got);
        end
        b_acc = 1'b1;
      end
      if (m_tvalid === 1'b1) begin
        checks++;
        if (m_tdata !== exp_d[got] || m_tlast !== exp_l[got]) begin
          errors++;
          $display("FAIL b2b_beat: idx=%0d data=%h last=%b required %h %b",
                   got, m_tdata, m_tlast, exp_d[got], exp_l[got]);
        end
        got++;
      end
      tick();
      k++;
      if (b_acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    m_tready  = 1'b0;
    checks++;
    if (got != 6 || !b_acc) begin
      errors++;
      $display("FAIL b2b_timeout: beats=%0d b_accepted=%b required 6 1", got, b_acc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stale = 0;
    int fk;
    wait_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 8'h00;
    cmd_len   = 8'd31;
    m_tready  = 1'b0;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (addrb !== 8'h03) begin
      errors++;
      $display("FAIL pre_reset_addrb: got %h required 03", addrb);
    end
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b ready=%b required 0 0 1", m_tvalid, busy, cmd_ready);
    end
    m_tready = 1'b1;
    repeat (10) begin
      if (m_tvalid !== 1'b0) stale++;
      tick();
    end
    m_tready = 1'b0;
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale_beats: saw %0d required 0", stale);
    end
    run_burst(8'h05, 0, 0, 1'b0, fk);
  endtask

  task automatic test_zero_stall();
    int fk;
    run_burst(0, 7, 3, 1'b1, fk);
  endtask

  task automatic test_random();
    int fk;
    for (int r = 0; r < 5; r++) begin
      run_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 24)), 2, 1'b0, fk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h100 + 32'(i);
    sync_reset = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    m_tready   = 1'b0;
    test_reset();
    test_single();
    test_full_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_zero_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
